seven_seg_scan_decoder: RTL and testbench

SEVEN_SEG_SCAN_DECODER -- requirements
Module: seven_seg_scan_decoder

---
 rtl/seven_seg_pkg.sv | 28 ++
 rtl/seg7_to_hex.sv | 23 ++
 rtl/seven_seg_scan_decoder.sv | 137 +++++++++++++
 tb/tb_seven_seg_scan_decoder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan decoder: FSM states, the scan
// sample layout, the blank pattern, the 16 legal cathode patterns and the digit count.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    LOCKED
  } scan_state_t;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] ca;
    logic       dp;
  } scan_t;

  // Every line undriven (all active-low signals high) reads as a blank display.
  localparam scan_t SCAN_BLANK = '{an: 8'hFF, ca: 7'h7F, dp: 1'b1};

  // Active-low cathode patterns for hex values 0..F, with Ca[0]=a .. Ca[6]=g.
  localparam logic [6:0] SEG_PATTERN [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational cathode-pattern decoder: maps an active-low 7-segment pattern
// to its hex nibble and flags whether the pattern is one of the 16 legal glyphs.
module seg7_to_hex
  import seven_seg_pkg::*;
(
  input  logic [6:0] ca,
  output logic [3:0] nibble,
  output logic       legal
);

  always_comb begin
    // NOTE: every output gets a default before the search so no latch is inferred.
    nibble = 4'h0;
    legal  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (ca == SEG_PATTERN[i]) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Recovers hex digits from a multiplexed 8-digit seven-segment display bus.
// Define SEG_SCAN_TIMEOUT_EN to enable the stale-digit watchdog.
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              AN,
  input  logic [6:0]              Ca,
  input  logic                    DP,
  output logic [31:0]             hex_value,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    err_illegal,
  output logic                    err_multi
);

  scan_t                 sync1, sync2, last;
  scan_state_t           state;
  logic [7:0]            cnt;
  logic [NUM_DIGITS-1:0] seen, seen_base, seen_next, anodes;
  logic                  changed, accept, single, multi, legal;
  logic [3:0]            nibble;
  logic [2:0]            idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= SCAN_BLANK;
      sync2 <= SCAN_BLANK;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so both flops shift together.
      sync1 <= '{an: AN, ca: Ca, dp: DP};
      sync2 <= sync1;
    end
  end

  assign changed = (sync2 != last);
  assign accept  = (state == SETTLE) && !changed && (cnt == 8'(STABLE_CYCLES - 1));

  // The counter only advances in SETTLE, so once LOCKED it stays saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
      last  <= SCAN_BLANK;
    end else if (changed) begin
      state <= SETTLE;
      cnt   <= 8'd1;
      last  <= sync2;
    end else begin
      case (state)
        SETTLE: begin
          if (accept) begin
            state <= LOCKED;
            cnt   <= 8'(STABLE_CYCLES);
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= state;
      endcase
    end
  end

  always_comb begin
    anodes = ~last.an;
    idx    = 3'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (anodes[k]) idx = 3'(k);
    end
    single    = (anodes != '0) && ((anodes & (anodes - NUM_DIGITS'(1))) == '0);
    multi     = (anodes != '0) && !single;
    seen_base = (seen == '1) ? '0 : seen;
    seen_next = seen_base | anodes;
  end

  seg7_to_hex u_seg7_to_hex (
    .ca     (last.ca),
    .nibble (nibble),
    .legal  (legal)
  );

`ifdef SEG_SCAN_TIMEOUT_EN
  logic [31:0] idle_cnt;
`endif

  // A full seen mask lives for one cycle alongside the frame_done pulse, then clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_value   <= '0;
      dp_out      <= '0;
      digit_valid <= '0;
      seen        <= '0;
      frame_done  <= 1'b0;
      err_illegal <= 1'b0;
      err_multi   <= 1'b0;
`ifdef SEG_SCAN_TIMEOUT_EN
      idle_cnt    <= '0;
`endif
    end else begin
      frame_done  <= 1'b0;
      err_illegal <= 1'b0;
      err_multi   <= 1'b0;
      seen        <= seen_base;
`ifdef SEG_SCAN_TIMEOUT_EN
      if (accept && single && legal) begin
        idle_cnt <= '0;
      end else if (idle_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
        idle_cnt    <= '0;
        digit_valid <= '0;
        seen        <= '0;
      end else begin
        idle_cnt <= idle_cnt + 32'd1;
      end
`endif
      if (accept) begin
        if (single && legal) begin
          hex_value[idx*4 +: 4] <= nibble;
          digit_valid[idx]      <= 1'b1;
          dp_out[idx]           <= ~last.dp;
          seen                  <= seen_next;
          frame_done            <= (seen_next == '1);
        end else if (single) begin
          err_illegal      <= 1'b1;
          digit_valid[idx] <= 1'b0;
        end else if (multi) begin
          err_multi <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Randomised self-checking bench for seven_seg_scan_decoder against a sliding-window
// reference model; the watchdog scenario runs when SEG_SCAN_TIMEOUT_EN is defined.
module tb_seven_seg_scan_decoder;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  AN  = 8'hFF;
  logic [6:0]  Ca  = 7'h7F;
  logic        DP  = 1'b1;
  logic [31:0] hex_value;
  logic [7:0]  dp_out, digit_valid;
  logic        frame_done, err_illegal, err_multi;

  seven_seg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .AN          (AN),
    .Ca          (Ca),
    .DP          (DP),
    .hex_value   (hex_value),
    .dp_out      (dp_out),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .err_illegal (err_illegal),
    .err_multi   (err_multi)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a pattern is taken once it has been sampled STABLE times in a
  // row after a different sample, and takes effect two edges after its last sample.
  logic [6:0]  glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [15:0] hist [$];
  logic [3:0]  m_hex [8];
  logic [7:0]  m_valid, m_dp, m_seen;
  logic        e_frame, e_ill, e_multi;
  int          idle;
  int          n_frame, n_ill, n_multi;

  function automatic int glyph_value(input logic [6:0] ca);
    glyph_value = -1;
    for (int i = 0; i < 16; i++) if (glyph[i] == ca) glyph_value = i;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (STABLE + 3) hist.push_back(16'hFFFF);
    for (int k = 0; k < 8; k++) m_hex[k] = 4'h0;
    m_valid = '0; m_dp = '0; m_seen = '0;
    e_frame = 0; e_ill = 0; e_multi = 0;
    idle = 0;
  endtask

  task automatic model_edge();
    int l, k, nlow, v;
    bit acc, good;
    logic [15:0] p;
    logic [7:0]  low;
    hist.push_back({AN, Ca, DP});
    if (hist.size() > 64) void'(hist.pop_front());
    l = hist.size() - 1;
    acc = (hist[l-2-STABLE] != hist[l-1-STABLE]);
    for (int i = l - 1 - STABLE; i < l - 2; i++) if (hist[i] != hist[i+1]) acc = 0;
    e_frame = 0; e_ill = 0; e_multi = 0; good = 0;
    if (acc) begin
      p    = hist[l-2];
      low  = ~p[15:8];
      nlow = $countones(low);
      k    = 0;
      for (int i = 0; i < 8; i++) if (low[i]) k = i;
      if (nlow == 1) begin
        v = glyph_value(p[7:1]);
        if (v >= 0) begin
          m_hex[k] = 4'(v); m_valid[k] = 1; m_dp[k] = ~p[0]; m_seen[k] = 1; good = 1;
          if (m_seen == 8'hFF) begin e_frame = 1; m_seen = '0; end
        end else begin
          e_ill = 1; m_valid[k] = 0;
        end
      end else if (nlow > 1) begin
        e_multi = 1;
      end
    end
`ifdef SEG_SCAN_TIMEOUT_EN
    if (good) idle = 0;
    else begin
      idle++;
      if (idle == TIMEOUT) begin m_valid = '0; m_seen = '0; idle = 0; end
    end
`endif
  endtask

  function automatic logic [31:0] m_hex_word();
    logic [31:0] w;
    for (int k = 0; k < 8; k++) w[4*k +: 4] = m_hex[k];
    return w;
  endfunction

  // One clock with the given inputs: drive at negedge, model at posedge, compare at negedge.
  task automatic cycle(input logic [7:0] an, input logic [6:0] ca, input logic dp);
    AN = an; Ca = ca; DP = dp;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("hex_value",   hex_value,   m_hex_word());
    check("dp_out",      dp_out,      m_dp);
    check("digit_valid", digit_valid, m_valid);
    check("frame_done",  frame_done,  e_frame);
    check("err_illegal", err_illegal, e_ill);
    check("err_multi",   err_multi,   e_multi);
    n_frame += int'(frame_done);
    n_ill   += int'(err_illegal);
    n_multi += int'(err_multi);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_hex",   hex_value,   32'h0);
    check("rst_dp",    dp_out,      8'h00);
    check("rst_valid", digit_valid, 8'h00);
    check("rst_pulse", {frame_done, err_illegal, err_multi}, 3'b000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic clear_counts();
    n_frame = 0; n_ill = 0; n_multi = 0;
  endtask

  initial begin
    logic [7:0] an;
    logic [6:0] ca;
    int r, a, b;
    model_reset();
    clear_counts();
    @(negedge clk);
    do_reset();

    // Single digit capture and its latency from input change to output.
    repeat (5) cycle(8'hFE, 7'h12, 1'b0);
    check("lat_before", digit_valid, 8'h00);
    cycle(8'hFE, 7'h12, 1'b0);
    check("lat_valid", digit_valid, 8'h01);
    check("lat_nibble", hex_value[3:0], 4'h5);
    check("lat_dp", dp_out[0], 1'b1);
    repeat (4) cycle(8'hFE, 7'h12, 1'b0);

    // Full scan of digits 0..7 carrying values 0..7.
    do_reset();
    clear_counts();
    for (int d = 0; d < 8; d++) repeat (8) cycle(~(8'h01 << d), glyph[d], 1'b1);
    repeat (2) cycle(8'hFF, 7'h7F, 1'b1);
    check("scan_hex", hex_value, 32'h76543210);
    check("scan_valid", digit_valid, 8'hFF);
    check("scan_frames", n_frame, 1);

    // Two anodes low at once.
    clear_counts();
    repeat (8) cycle(8'hFC, 7'h00, 1'b0);
    check("multi_pulses", n_multi, 1);
    check("multi_hex", hex_value, 32'h76543210);
    check("multi_valid", digit_valid, 8'hFF);

    // Illegal glyph on a valid digit.
    clear_counts();
    repeat (8) cycle(8'hF7, 7'h7F, 1'b0);
    check("illegal_pulses", n_ill, 1);
    check("illegal_valid", digit_valid, 8'hF7);
    check("illegal_hex", hex_value, 32'h76543210);

    // Anodes toggling faster than the settle window, then a reset mid-settle.
    clear_counts();
    for (int t = 0; t < 8; t++) repeat (3) cycle(t[0] ? 8'hFD : 8'hFE, 7'h40, 1'b0);
    check("toggle_pulses", n_frame + n_ill + n_multi, 0);
    check("toggle_valid", digit_valid, 8'hF7);
    repeat (3) cycle(8'hFB, 7'h40, 1'b0);
    do_reset();
    repeat (5) cycle(8'hFB, 7'h40, 1'b0);
    check("post_rst_wait", digit_valid, 8'h00);
    cycle(8'hFB, 7'h40, 1'b0);
    check("post_rst_take", digit_valid, 8'h04);

    // Random traffic: mostly single digits, some multi-anode, blank and bad glyphs.
    repeat (300) begin
      r = $urandom_range(0, 9);
      a = $urandom_range(0, 7);
      if (r < 6) an = ~(8'h01 << a);
      else if (r < 8) begin
        b  = (a + 1 + $urandom_range(0, 6)) % 8;
        an = ~((8'h01 << a) | (8'h01 << b));
      end else an = 8'hFF;
      ca = ($urandom_range(0, 4) == 0) ? 7'($urandom) : glyph[$urandom_range(0, 15)];
      b  = $urandom_range(1, 8);
      r  = $urandom_range(0, 1);
      repeat (b) cycle(an, ca, r[0]);
    end

`ifdef SEG_SCAN_TIMEOUT_EN
    // Watchdog: digit_valid drops exactly TIMEOUT cycles after the last good capture.
    do_reset();
    repeat (6) cycle(8'hFE, 7'h40, 1'b1);
    check("wd_capture", digit_valid, 8'h01);
    repeat (2) cycle(8'hFE, 7'h40, 1'b1);
    repeat (TIMEOUT - 3) cycle(8'hFF, 7'h7F, 1'b1);
    check("wd_before", digit_valid, 8'h01);
    cycle(8'hFF, 7'h7F, 1'b1);
    check("wd_expired", digit_valid, 8'h00);
    check("wd_hex_kept", hex_value[3:0], 4'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
